// File: rtl/type_pkg.sv
// Shared bus types plus the data-cache state encoding and default address-field widths.
// Address fields at default geometry: offset[1:0], word[3:2], index[7:4], tag[31:8].
package type_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  byte_en_t;

  localparam int OFFSET_W = 2;
  localparam int WORD_W   = 2;
  localparam int INDEX_W  = 4;
  localparam int TAG_W    = 32 - INDEX_W - WORD_W - OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } dcache_state_t;

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data store: byte-write-enabled synchronous write port, asynchronous read port.
// Left unreset; the valid bits in the controller decide what contents mean anything.
module dcache_data_ram
  import type_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_waddr,
  input  byte_en_t      i_we,
  input  data_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output data_t         o_rdata
);

  logic [3:0][7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_waddr][b] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache between an LSU and memory.
// Load hit answers one cycle after acceptance; misses refill the whole line word by word.
module dcache
  import type_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     cpu_valid,
  input  addr_t    cpu_addr,
  input  data_t    cpu_wdata,
  input  byte_en_t cpu_byte_enable,
  output logic     cpu_ready,
  output data_t    cpu_rdata,
  output logic     mem_valid,
  output logic     mem_we,
  output addr_t    mem_addr,
  output data_t    mem_wdata,
  output byte_en_t mem_byte_enable,
  input  logic     mem_ready,
  input  data_t    mem_rdata
);

  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 32 - OFFSET_W - WW - IW;
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS_PER_LINE - 1);

  dcache_state_t r_state, w_next;

  addr_t            r_addr;
  data_t            r_wdata;
  byte_en_t         r_be;
  logic [WW-1:0]    r_cnt;
  logic [NUM_LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag [NUM_LINES];

  logic [IW-1:0]    w_cpu_idx, w_req_idx;
  logic [TW-1:0]    w_cpu_tag, w_req_tag;
  logic [WW-1:0]    w_req_word;
  logic             w_cpu_hit, w_req_hit;
  logic             w_accept, w_fill_done;
  byte_en_t         w_ram_we;
  logic [IW+WW-1:0] w_ram_waddr;
  data_t            w_ram_wdata, w_ram_rdata;
  logic             w_unused;

  assign w_cpu_idx  = cpu_addr[OFFSET_W+WW +: IW];
  assign w_cpu_tag  = cpu_addr[31 -: TW];
  assign w_req_idx  = r_addr[OFFSET_W+WW +: IW];
  assign w_req_tag  = r_addr[31 -: TW];
  assign w_req_word = r_addr[OFFSET_W +: WW];
  assign w_cpu_hit  = r_valid[w_cpu_idx] && (r_tag[w_cpu_idx] == w_cpu_tag);
  assign w_req_hit  = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
  assign w_unused   = ^{cpu_addr[OFFSET_W-1:0], r_addr[OFFSET_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    w_fill_done     = 1'b0;
    w_ram_we        = '0;
    w_ram_waddr     = {w_req_idx, w_req_word};
    w_ram_wdata     = r_wdata;
    cpu_ready       = 1'b0;
    mem_valid       = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    case (r_state)
      ST_IDLE: begin
        if (cpu_valid) begin
          w_accept = 1'b1;
          if (cpu_byte_enable != '0) w_next = ST_WRITE;
          else if (w_cpu_hit)        w_next = ST_RESP;
          else                       w_next = ST_REFILL;
        end
      end
      ST_REFILL: begin
        mem_valid = 1'b1;
        mem_addr  = {r_addr[31:OFFSET_W+WW], r_cnt, {OFFSET_W{1'b0}}};
        if (mem_ready) begin
          w_ram_we    = '1;
          w_ram_waddr = {w_req_idx, r_cnt};
          w_ram_wdata = mem_rdata;
          if (r_cnt == LAST_WORD) begin
            w_fill_done = 1'b1;
            w_next      = ST_RESP;
          end
        end
      end
      ST_WRITE: begin
        mem_valid       = 1'b1;
        mem_we          = 1'b1;
        mem_addr        = {r_addr[31:OFFSET_W], {OFFSET_W{1'b0}}};
        mem_wdata       = r_wdata;
        mem_byte_enable = r_be;
        if (mem_ready) begin
          // No-write-allocate: only a line already holding this address sees the store.
          if (w_req_hit) w_ram_we = r_be;
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        cpu_ready = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign cpu_rdata = cpu_ready ? w_ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_cnt   <= '0;
      r_valid <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        r_be    <= cpu_byte_enable;
        r_cnt   <= '0;
      end
      if (r_state == ST_REFILL && mem_ready) r_cnt <= r_cnt + 1'b1;
      if (w_fill_done) r_valid[w_req_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fill_done) r_tag[w_req_idx] <= w_req_tag;
  end

  dcache_data_ram #(
    .DEPTH(NUM_LINES * WORDS_PER_LINE),
    .AW   (IW + WW)
  ) u_data_ram (
    .i_clk  (clk),
    .i_waddr(w_ram_waddr),
    .i_we   (rst ? 4'b0000 : w_ram_we),
    .i_wdata(w_ram_wdata),
    .i_raddr({w_req_idx, w_req_word}),
    .o_rdata(w_ram_rdata)
  );

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: acts as the backing memory, runs a directed vector table, a reset-abort
// sequence and a randomized phase checked against a line-presence plus flat-memory model.
module tb_dcache;
  import type_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     cpu_valid;
  addr_t    cpu_addr;
  data_t    cpu_wdata;
  byte_en_t cpu_byte_enable;
  logic     cpu_ready;
  data_t    cpu_rdata;
  logic     mem_valid, mem_we;
  addr_t    mem_addr;
  data_t    mem_wdata;
  byte_en_t mem_byte_enable;
  logic     mem_ready;
  data_t    mem_rdata;

  always #5 clk = ~clk;

  dcache #(.NUM_LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byte_enable(cpu_byte_enable), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_byte_enable(mem_byte_enable), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference: flat word memory plus which tag each direct-mapped line holds.
  data_t mem_model [addr_t];
  bit    m_valid [16];
  int    m_tag   [16];

  function automatic data_t init_word(addr_t a);
    return (a * 32'h0100_0193) ^ 32'h5EED_1234;
  endfunction

  function automatic data_t mem_rd(addr_t a);
    if (mem_model.exists(a)) return mem_model[a];
    return init_word(a);
  endfunction

  function automatic int idx_of(addr_t a);
    return int'((a / 16) % 16);
  endfunction

  function automatic int tag_of(addr_t a);
    return int'(a / 256);
  endfunction

  data_t    t_rd, t_w_data;
  addr_t    t_w_addr;
  byte_en_t t_w_be;
  int       t_cyc, t_nrd, t_nwr, t_bad_addr, t_unstable, t_quiet_err;
  bit       t_timeout, t_aborted, t_pulse_err;

  // Drive one request and play memory with 'lat' wait cycles per beat.
  // rst_at > 0 raises rst together with that read beat's mem_ready.
  task automatic do_req(input addr_t a, input data_t wd, input byte_en_t be,
                        input int lat, input int rst_at);
    int    w;
    bit    done;
    addr_t prev, base;
    data_t cur, merged;
    base = a & 32'hFFFF_FFF0;
    t_rd = '0; t_cyc = 0; t_nrd = 0; t_nwr = 0; t_bad_addr = 0; t_unstable = 0;
    t_quiet_err = 0; t_timeout = 0; t_aborted = 0; t_pulse_err = 0;
    t_w_addr = '0; t_w_data = '0; t_w_be = '0;
    prev = '0; w = 0; done = 0;
    cpu_valid = 1'b1; cpu_addr = a; cpu_wdata = wd; cpu_byte_enable = be; mem_ready = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      t_cyc++;
      mem_ready = 1'b0;
      if (cpu_ready) begin
        t_rd = cpu_rdata;
        if (mem_valid) t_quiet_err++;
        done = 1;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byte_enable = '0;
      end else begin
        if (cpu_rdata !== '0) t_quiet_err++;
        if (mem_valid) begin
          if (w > 0 && mem_addr !== prev) t_unstable++;
          prev = mem_addr;
          if (w >= lat) begin
            w = 0;
            mem_ready = 1'b1;
            if (mem_we) begin
              t_nwr++;
              t_w_addr = mem_addr; t_w_data = mem_wdata; t_w_be = mem_byte_enable;
              cur = mem_rd(mem_addr);
              for (int b = 0; b < 4; b++)
                merged[8*b +: 8] = mem_byte_enable[b] ? mem_wdata[8*b +: 8] : cur[8*b +: 8];
              mem_model[mem_addr] = merged;
              mem_rdata = $urandom;
            end else begin
              if (mem_addr !== base + addr_t'(4 * t_nrd)) t_bad_addr++;
              mem_rdata = mem_rd(mem_addr);
              t_nrd++;
              if (t_nrd == rst_at) begin
                rst = 1'b1; t_aborted = 1; done = 1;
                cpu_valid = 1'b0; cpu_byte_enable = '0;
              end
            end
          end else begin
            w++;
          end
        end else begin
          w = 0;
          if ({mem_we, mem_addr, mem_wdata, mem_byte_enable} !== '0) t_quiet_err++;
        end
      end
      if (!done && t_cyc > 300) begin
        t_timeout = 1; done = 1; cpu_valid = 1'b0;
      end
    end
    if (!t_aborted && !t_timeout) begin
      @(posedge clk); #1;
      t_pulse_err = cpu_ready;
    end
  endtask

  task automatic chk_common(input string nm);
    chk({nm, ".timeout"}, 32'(t_timeout), 0);
    chk({nm, ".quiet"}, 32'(t_quiet_err), 0);
    chk({nm, ".unstable"}, 32'(t_unstable), 0);
    chk({nm, ".pulse"}, 32'(t_pulse_err), 0);
    chk({nm, ".refill_addr"}, 32'(t_bad_addr), 0);
  endtask

  // Model-driven request used by the randomized phase.
  task automatic run_model(input string nm, input addr_t a, input data_t wd,
                           input byte_en_t be, input int lat);
    int ix;
    bit hit;
    ix  = idx_of(a);
    hit = m_valid[ix] && (m_tag[ix] == tag_of(a));
    do_req(a, wd, be, lat, 0);
    chk_common(nm);
    if (be == '0) begin
      chk({nm, ".rdata"}, t_rd, mem_rd(a));
      chk({nm, ".reads"}, 32'(t_nrd), hit ? 0 : 4);
      chk({nm, ".writes"}, 32'(t_nwr), 0);
      if (hit) chk({nm, ".hit_lat"}, 32'(t_cyc), 1);
      m_valid[ix] = 1'b1;
      m_tag[ix]   = tag_of(a);
    end else begin
      chk({nm, ".reads"}, 32'(t_nrd), 0);
      chk({nm, ".writes"}, 32'(t_nwr), 1);
      chk({nm, ".waddr"}, t_w_addr, a);
      chk({nm, ".wdata"}, t_w_data, wd);
      chk({nm, ".wbe"}, 32'(t_w_be), 32'(be));
    end
  endtask

  typedef struct {
    addr_t    a;
    data_t    wd;
    byte_en_t be;
    int       lat;
    int       exp_nrd;
    int       exp_nwr;
    bit       chk_rd;
    data_t    exp_rd;
    int       exp_cyc;
  } vec_t;

  function automatic vec_t mk(addr_t a, data_t wd, byte_en_t be, int lat,
                              int nrd, int nwr, bit crd, data_t rd, int cyc);
    vec_t v;
    v.a = a; v.wd = wd; v.be = be; v.lat = lat; v.exp_nrd = nrd; v.exp_nwr = nwr;
    v.chk_rd = crd; v.exp_rd = rd; v.exp_cyc = cyc;
    return v;
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1; cpu_valid = 1'b0; mem_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("reset.cpu_ready", 32'(cpu_ready), 0);
    chk("reset.mem_valid", 32'(mem_valid), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset.cpu_ready", 32'(cpu_ready), 0);
    chk("post_reset.mem_valid", 32'(mem_valid), 0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  vec_t  vecs [13];
  data_t w108, w_exp;
  string nm;

  initial begin
    rst = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byte_enable = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    w108  = init_word(32'h108);
    w_exp = {16'hAABB, w108[15:0]};

    vecs[0]  = mk(32'h100,  0, 4'b0000, 0, 4, 0, 1, init_word(32'h100),  0);
    vecs[1]  = mk(32'h104,  0, 4'b0000, 0, 0, 0, 1, init_word(32'h104),  1);
    vecs[2]  = mk(32'h108,  32'hAABBCCDD, 4'b1100, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(32'h108,  0, 4'b0000, 0, 0, 0, 1, w_exp, 1);
    vecs[4]  = mk(32'h200,  32'h11223344, 4'b1111, 1, 0, 1, 0, 0, 0);
    vecs[5]  = mk(32'h200,  0, 4'b0000, 0, 4, 0, 1, 32'h11223344, 0);
    vecs[6]  = mk(32'h1100, 0, 4'b0000, 0, 4, 0, 1, init_word(32'h1100), 0);
    vecs[7]  = mk(32'h100,  0, 4'b0000, 0, 4, 0, 1, init_word(32'h100),  0);
    vecs[8]  = mk(32'h108,  0, 4'b0000, 0, 0, 0, 1, w_exp, 1);
    vecs[9]  = mk(32'h1104, 0, 4'b0000, 5, 4, 0, 1, init_word(32'h1104), 0);
    vecs[10] = mk(32'h1108, 0, 4'b0000, 2, 0, 0, 1, init_word(32'h1108), 1);
    vecs[11] = mk(32'h1200, 32'h99887766, 4'b0011, 5, 0, 1, 0, 0, 0);
    vecs[12] = mk(32'h1104, 0, 4'b0000, 0, 0, 0, 1, init_word(32'h1104), 1);

    do_reset(3);

    for (int i = 0; i < 13; i++) begin
      nm = $sformatf("vec%0d", i);
      do_req(vecs[i].a, vecs[i].wd, vecs[i].be, vecs[i].lat, 0);
      chk_common(nm);
      chk({nm, ".reads"}, 32'(t_nrd), 32'(vecs[i].exp_nrd));
      chk({nm, ".writes"}, 32'(t_nwr), 32'(vecs[i].exp_nwr));
      if (vecs[i].chk_rd) chk({nm, ".rdata"}, t_rd, vecs[i].exp_rd);
      if (vecs[i].exp_cyc != 0) chk({nm, ".latency"}, 32'(t_cyc), 32'(vecs[i].exp_cyc));
      if (vecs[i].exp_nwr != 0) begin
        chk({nm, ".waddr"}, t_w_addr, vecs[i].a);
        chk({nm, ".wdata"}, t_w_data, vecs[i].wd);
        chk({nm, ".wbe"}, 32'(t_w_be), 32'(vecs[i].be));
      end
    end

    // Reset lands on the second refill beat; the line must come back invalid.
    do_reset(2);
    do_req(32'h100, 0, 4'b0000, 1, 2);
    chk("abort.reached", 32'(t_aborted), 1);
    @(posedge clk); #1;
    chk("abort.mem_valid", 32'(mem_valid), 0);
    chk("abort.cpu_ready", 32'(cpu_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort.after.mem_valid", 32'(mem_valid), 0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    run_model("abort.reload", 32'h100, 0, 4'b0000, 0);
    chk("abort.reload_missed", 32'(t_nrd), 4);

    do_reset(2);
    for (int n = 0; n < 300; n++) begin
      addr_t    a;
      byte_en_t be;
      a  = (addr_t'($urandom_range(0, 2)) << 8) | (addr_t'($urandom_range(0, 3)) << 4)
         | (addr_t'($urandom_range(0, 3)) << 2);
      be = ($urandom_range(0, 9) < 6) ? 4'b0000 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) begin
        // Stray memory completion while idle must be ignored.
        mem_ready = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("stray.mem_valid", 32'(mem_valid), 0);
        chk("stray.cpu_ready", 32'(cpu_ready), 0);
      end
      run_model($sformatf("rnd%0d", n), a, $urandom, be, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
